// File: rtl/umq_access_ctrl_if.sv
// rtl/umq_access_ctrl_if.sv - network/receive/result/UMQ signal bundle for umq_access_ctrl
interface umq_access_ctrl_if #(
  parameter int PKT_W = 128
) ();
  // network side: unmatched packets to be inserted
  logic             net_valid;
  logic [PKT_W-1:0] net_message;
  logic             net_ready;
  // receive side: posted receives to be looked up
  logic             rcv_valid;
  logic [31:0]      rcv_request;
  logic             rcv_ready;
  // find result port
  logic             res_valid;
  logic             res_ready;
  logic             res_found;
  logic             res_timeout;
  logic [PKT_W-1:0] res_message;
  // UMQ command/completion
  logic             umq_find;
  logic             umq_insert;
  logic [31:0]      umq_request;
  logic [PKT_W-1:0] umq_message;
  logic             umq_found;
  logic             umq_notfound;
  logic             umq_full;
  logic [PKT_W-1:0] umq_msg;

  // controller view
  modport slave (
    input  net_valid, net_message, rcv_valid, rcv_request, res_ready,
    input  umq_found, umq_notfound, umq_full, umq_msg,
    output net_ready, rcv_ready, res_valid, res_found, res_timeout, res_message,
    output umq_find, umq_insert, umq_request, umq_message
  );

  // requesters / UMQ / result consumer view
  modport master (
    output net_valid, net_message, rcv_valid, rcv_request, res_ready,
    output umq_found, umq_notfound, umq_full, umq_msg,
    input  net_ready, rcv_ready, res_valid, res_found, res_timeout, res_message,
    input  umq_find, umq_insert, umq_request, umq_message
  );
endinterface

// File: rtl/umq_access_ctrl.sv
// rtl/umq_access_ctrl.sv - UMQ access sequencer/arbiter; optional find watchdog via UMQ_FIND_TIMEOUT_EN
module umq_access_ctrl #(
  parameter int PKT_W        = 128,
  parameter int INS_WAIT     = 5,
  parameter int FIND_TIMEOUT = 4095
) (
  input  logic                i_clk,
  input  logic                i_rst,
  umq_access_ctrl_if.slave    io_bus
);

  // WAIT_INS lasts INS_WAIT-1 cycles: load INS_WAIT-2 and exit on zero
  localparam int                INS_CW   = $clog2(INS_WAIT);
  localparam logic [INS_CW-1:0] INS_LOAD = INS_CW'(INS_WAIT - 2);
  localparam logic [11:0]       TMO_LAST = 12'(FIND_TIMEOUT - 1);

`ifdef UMQ_FIND_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  // without the watchdog a find waits forever and res_timeout stays 0
  localparam logic TMO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_INS,
    S_WAIT_INS,
    S_ISSUE_FIND,
    S_WAIT_FIND,
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_last_net;   // 1 = last grant went to network side
  logic [INS_CW-1:0] r_ins_cnt;
  logic [11:0]       r_tmo_cnt;
  logic              r_insert;
  logic              r_find;
  logic [PKT_W-1:0]  r_message;
  logic [31:0]       r_request;
  logic              r_res_valid;
  logic              r_res_found;
  logic              r_res_timeout;
  logic [PKT_W-1:0]  r_res_message;

  logic w_net_elig;
  logic w_rcv_elig;
  logic w_grant_net;
  logic w_grant_rcv;
  logic w_tmo_hit;

  // round-robin grant, only offered while idle; ties go opposite the last grant
  always_comb begin
    w_net_elig  = io_bus.net_valid & ~io_bus.umq_full;
    w_rcv_elig  = io_bus.rcv_valid;
    w_grant_net = 1'b0;
    w_grant_rcv = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant_net = w_net_elig & (~w_rcv_elig | ~r_last_net);
      w_grant_rcv = w_rcv_elig & (~w_net_elig |  r_last_net);
    end
  end

  assign w_tmo_hit = TMO_EN & (r_tmo_cnt == TMO_LAST);

  // command sequencer: one UMQ command in flight, all outputs registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_last_net    <= 1'b0;
      r_ins_cnt     <= '0;
      r_tmo_cnt     <= '0;
      r_insert      <= 1'b0;
      r_find        <= 1'b0;
      r_message     <= '0;
      r_request     <= '0;
      r_res_valid   <= 1'b0;
      r_res_found   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_message <= '0;
    end else begin
      r_insert <= 1'b0;
      r_find   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_net) begin
            r_message  <= io_bus.net_message;
            r_insert   <= 1'b1;
            r_last_net <= 1'b1;
            r_state    <= S_ISSUE_INS;
          end else if (w_grant_rcv) begin
            r_request  <= io_bus.rcv_request;
            r_find     <= 1'b1;
            r_last_net <= 1'b0;
            r_state    <= S_ISSUE_FIND;
          end
        end
        S_ISSUE_INS: begin
          r_ins_cnt <= INS_LOAD;
          r_state   <= S_WAIT_INS;
        end
        S_WAIT_INS: begin
          // umq_full changes here are irrelevant: the insert is already committed
          if (r_ins_cnt == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_ins_cnt <= r_ins_cnt - INS_CW'(1);
          end
        end
        S_ISSUE_FIND: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT_FIND;
        end
        S_WAIT_FIND: begin
          // found beats notfound, and any strobe beats the watchdog
          if (io_bus.umq_found) begin
            r_res_valid   <= 1'b1;
            r_res_found   <= 1'b1;
            r_res_message <= io_bus.umq_msg;
            r_state       <= S_RESP;
          end else if (io_bus.umq_notfound) begin
            r_res_valid   <= 1'b1;
            r_res_found   <= 1'b0;
            r_res_message <= '0;
            r_state       <= S_RESP;
          end else if (w_tmo_hit) begin
            r_res_valid   <= 1'b1;
            r_res_found   <= 1'b0;
            r_res_timeout <= 1'b1;
            r_res_message <= '0;
            r_state       <= S_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 12'd1;
          end
        end
        S_RESP: begin
          if (io_bus.res_ready) begin
            r_res_valid   <= 1'b0;
            r_res_found   <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_message <= '0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.net_ready   = w_grant_net;
  assign io_bus.rcv_ready   = w_grant_rcv;
  assign io_bus.umq_insert  = r_insert;
  assign io_bus.umq_find    = r_find;
  assign io_bus.umq_message = r_message;
  assign io_bus.umq_request = r_request;
  assign io_bus.res_valid   = r_res_valid;
  assign io_bus.res_found   = r_res_found;
  assign io_bus.res_timeout = r_res_timeout;
  assign io_bus.res_message = r_res_message;

endmodule

// File: tb/tb_umq_access_ctrl.sv
// tb/tb_umq_access_ctrl.sv - directed bench for umq_access_ctrl
module tb_umq_access_ctrl;
  localparam int PKT_W = 128;
`ifdef UMQ_FIND_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4095;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  umq_access_ctrl_if #(.PKT_W(PKT_W)) bus ();

  umq_access_ctrl #(
    .PKT_W(PKT_W), .INS_WAIT(5), .FIND_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .io_bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic net_valid;
    logic umq_full;
    logic rcv_valid;
    logic exp_net_ready;
    logic exp_rcv_ready;
  } vec_t;

  vec_t vecs[8];

  // all outputs packed for reset checks
  function automatic logic [6:0] ctl_outs();
    return {bus.res_valid, bus.res_found, bus.res_timeout, bus.umq_find,
            bus.umq_insert, bus.net_ready, bus.rcv_ready};
  endfunction

  // present a receive request, return at the ISSUE_FIND cycle
  task automatic do_find(input logic [31:0] req, output bit ok);
    int n;
    @(negedge clk);
    bus.rcv_valid   = 1'b1;
    bus.rcv_request = req;
    #1;
    n = 0;
    while (!bus.rcv_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk);
    bus.rcv_valid = 1'b0;
    #1;
    ok = (bus.umq_find === 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cnt, bad, p1, p2, n_g, cd;
    logic [3:0] g_bits;
    logic [PKT_W-1:0] m1, m2;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    bus.net_valid = 0; bus.net_message = '0; bus.rcv_valid = 0; bus.rcv_request = '0;
    bus.res_ready = 0; bus.umq_found = 0; bus.umq_notfound = 0; bus.umq_full = 0;
    bus.umq_msg = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctl", ctl_outs(), 7'b0);
    check("reset_res_message", bus.res_message, 0);
    check("reset_umq_request", bus.umq_request, 0);
    check("reset_umq_message", bus.umq_message, 0);
    @(negedge clk);
    rst = 1'b0;

    // grant table: idle, last grant = RCV, inputs withdrawn before the edge
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.net_valid = vecs[i].net_valid;
      bus.umq_full  = vecs[i].umq_full;
      bus.rcv_valid = vecs[i].rcv_valid;
      #1;
      check($sformatf("vec%0d_net_ready", i), bus.net_ready, vecs[i].exp_net_ready);
      check($sformatf("vec%0d_rcv_ready", i), bus.rcv_ready, vecs[i].exp_rcv_ready);
      bus.net_valid = 0; bus.umq_full = 0; bus.rcv_valid = 0;
    end

    // find answered by notfound after 3 cycles
    do_find(32'h0001_0203, ok);
    check("t1_find_pulse", ok, 1);
    check("t1_umq_request", bus.umq_request, 32'h0001_0203);
    @(negedge clk); #1;
    check("t1_find_one_cycle", bus.umq_find, 0);
    @(negedge clk);
    @(negedge clk);
    bus.umq_notfound = 1'b1;
    @(negedge clk);
    bus.umq_notfound = 1'b0;
    #1;
    check("t1_res_valid", bus.res_valid, 1);
    check("t1_res_found", bus.res_found, 0);
    check("t1_res_timeout", bus.res_timeout, 0);
    check("t1_res_message", bus.res_message, 0);
    @(negedge clk); #1;
    check("t1_res_hold", bus.res_valid, 1);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    check("t1_res_clear", {bus.res_valid, bus.res_found}, 2'b00);

    // both requesters held: grants alternate, net first
    n_g = 0; g_bits = '0; cd = 0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.net_valid = 1'b1; bus.net_message = 128'hA5; bus.rcv_valid = 1'b1;
    bus.rcv_request = 32'h0004_0506;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (n_g >= 4) begin
        bus.net_valid = 1'b0; bus.rcv_valid = 1'b0;
      end
      bus.umq_notfound = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.umq_notfound = 1'b1;
      end
      if (bus.umq_find) cd = 2;
      #1;
      if (n_g < 4 && (bus.net_ready || bus.rcv_ready)) begin
        g_bits = {g_bits[2:0], bus.net_ready};
        n_g++;
      end
    end
    bus.umq_notfound = 1'b0;
    bus.res_ready    = 1'b0;
    check("rr_count", n_g, 4);
    check("rr_order", g_bits, 4'b1010);
    check("rr_idle_after", ctl_outs(), 7'b0);

    // full UMQ stalls the network side
    @(negedge clk);
    bus.umq_full = 1'b1; bus.net_valid = 1'b1; bus.net_message = 128'h77;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (bus.net_ready || bus.umq_insert) cnt++;
    end
    check("full_stall", cnt, 0);
    @(negedge clk);
    bus.umq_full = 1'b0;
    #1;
    check("full_drop_ready", bus.net_ready, 1);
    @(negedge clk);
    bus.net_valid = 1'b0;
    bus.umq_full  = 1'b1;
    #1;
    check("full_drop_insert", bus.umq_insert, 1);
    check("full_drop_message", bus.umq_message, 128'h77);
    repeat (6) @(negedge clk);
    bus.umq_full = 1'b0;

    // back-to-back inserts: pulse spacing and held message
    m1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    m2 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    p1 = -1; p2 = -1; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.net_valid = 1'b1; bus.net_message = m1;
      end
      if (i == 1) bus.net_message = m2;
      #1;
      if (bus.umq_insert) begin
        if (p1 < 0) begin
          p1 = i;
          check("b2b_msg1", bus.umq_message, m1);
        end else if (p2 < 0) begin
          p2 = i;
          check("b2b_msg2", bus.umq_message, m2);
        end
      end else if (p1 >= 0 && p2 < 0 && bus.umq_message !== m1) begin
        bad++;
      end
    end
    bus.net_valid = 1'b0;
    check("b2b_first_pulse", p1, 1);
    check("b2b_spacing", p2 - p1, 6);
    check("b2b_msg_stable", bad, 0);
    repeat (6) @(negedge clk);

    // strobes while idle are ignored
    bus.umq_found = 1'b1; bus.umq_msg = 128'hBEEF;
    @(negedge clk);
    bus.umq_found = 1'b0; bus.umq_msg = '0;
    #1;
    check("stray_idle", bus.res_valid, 0);

    // found and notfound together: found wins, result held
    do_find(32'h0005_0607, ok);
    check("t5_find_pulse", ok, 1);
    @(negedge clk);
    bus.umq_found = 1'b1; bus.umq_notfound = 1'b1; bus.umq_msg = 128'hDEAD;
    @(negedge clk);
    bus.umq_found = 1'b0; bus.umq_notfound = 1'b0; bus.umq_msg = '0;
    #1;
    check("t5_res_valid", bus.res_valid, 1);
    check("t5_res_found", bus.res_found, 1);
    check("t5_res_message", bus.res_message, 128'hDEAD);
    check("t5_res_timeout", bus.res_timeout, 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.umq_notfound = (c == 3);
      #1;
      if (bus.res_valid !== 1'b1 || bus.res_found !== 1'b1 || bus.res_message !== 128'hDEAD
          || bus.rcv_ready !== 1'b0)
        bad++;
    end
    bus.umq_notfound = 1'b0;
    check("t5_res_held", bad, 0);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    check("t5_res_clear", {bus.res_valid, bus.res_found, bus.res_message}, 0);

`ifdef UMQ_FIND_TIMEOUT_EN
    // watchdog expiry with no strobe
    do_find(32'h0008_090A, ok);
    check("t6_find_pulse", ok, 1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk); #1;
    end
    check("t6_not_early", bus.res_valid, 0);
    @(negedge clk); #1;
    check("t6_res_valid", bus.res_valid, 1);
    check("t6_res_timeout", bus.res_timeout, 1);
    check("t6_res_found", bus.res_found, 0);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    check("t6_res_clear", bus.res_timeout, 0);
`endif

    // async reset while waiting for the UMQ answer
    do_find(32'h00AA_BBCC, ok);
    check("rst_find_pulse", ok, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctl", ctl_outs(), 7'b0);
    check("rst_async_request", bus.umq_request, 0);
    check("rst_async_message", {bus.res_message, bus.umq_message}, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.umq_notfound = 1'b1;
    @(negedge clk);
    bus.umq_notfound = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_no_result", bus.res_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
